// File: rtl/cmip_fifo_burst_rdr_if.sv
// Handshake bundle for cmip_fifo_burst_rdr: control, FIFO read side and output stream.
// The slave modport is the reader itself; master is whatever drives it.
interface cmip_fifo_burst_rdr_if #(
   parameter int DATA_WDTH = 512,
   parameter int LEN_WDTH  = 16
);
   logic                 i_start;
   logic [LEN_WDTH-1:0]  i_burst_len;
   logic                 o_busy;
   logic                 o_done;
   logic                 i_fifo_empty;
   logic                 o_fifo_rd;
   logic [DATA_WDTH-1:0] i_fifo_dout;
   logic                 o_vld;
   logic                 i_rdy;
   logic [DATA_WDTH-1:0] o_data;
   logic                 o_last;

   modport slave (
      input  i_start, i_burst_len, i_fifo_empty, i_fifo_dout, i_rdy,
      output o_busy, o_done, o_fifo_rd, o_vld, o_data, o_last
   );
   modport master (
      output i_start, i_burst_len, i_fifo_empty, i_fifo_dout, i_rdy,
      input  o_busy, o_done, o_fifo_rd, o_vld, o_data, o_last
   );
endinterface

// File: rtl/cmip_fifo_burst_rdr.sv
// Burst reader: pulls a latched number of words from a non-FWFT FIFO into a valid/ready stream
// through a 2-entry skid buffer. Define CMIP_FIFO_BURST_RDR_STAT_EN to add the o_stat_bursts counter.
module cmip_fifo_burst_rdr #(
   parameter int DATA_WDTH = 512,
   parameter int LEN_WDTH  = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
`ifdef CMIP_FIFO_BURST_RDR_STAT_EN
   output logic [31:0]               o_stat_bursts,
`endif
   cmip_fifo_burst_rdr_if.slave      bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [LEN_WDTH-1:0]  len_q, len_d;
   logic [LEN_WDTH:0]    rd_cnt_q, rd_cnt_d;
   logic [LEN_WDTH:0]    beat_q, beat_d;
   logic [1:0]           buf_cnt_q, buf_cnt_d;
   logic                 infl_q, infl_d;
   logic [DATA_WDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
   logic                 pop, rd, last;
   logic [2:0]           occ;
   logic [1:0]           tail;

   always_comb begin
      pop  = (buf_cnt_q != 2'd0) && bus.i_rdy;
      last = (buf_cnt_q != 2'd0) && ((beat_q + 1'b1) == {1'b0, len_q});
      // Occupancy counts the in-flight read so the buffer never overflows when data lands.
      occ  = {1'b0, buf_cnt_q} + {2'b00, infl_q};
      rd   = (state_q == RUN) && !bus.i_fifo_empty && (rd_cnt_q < {1'b0, len_q}) &&
             (occ < (3'd2 + {2'b00, pop}));
      tail = buf_cnt_q - {1'b0, pop};

      state_d   = state_q;
      len_d     = len_q;
      rd_cnt_d  = rd_cnt_q;
      beat_d    = beat_q;
      buf0_d    = buf0_q;
      buf1_d    = buf1_q;
      infl_d    = rd;
      buf_cnt_d = buf_cnt_q - {1'b0, pop} + {1'b0, infl_q};

      if (rd)  rd_cnt_d = rd_cnt_q + 1'b1;
      if (pop) beat_d   = beat_q + 1'b1;

      case (state_q)
         IDLE: if (bus.i_start) begin
            len_d    = bus.i_burst_len;
            rd_cnt_d = '0;
            beat_d   = '0;
            state_d  = (bus.i_burst_len == '0) ? DONE : RUN;
         end
         RUN:  if (pop && last) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (pop) buf0_d = buf1_q;
      if (infl_q) begin
         if (tail == 2'd0) buf0_d = bus.i_fifo_dout;
         else              buf1_d = bus.i_fifo_dout;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         rd_cnt_q  <= '0;
         beat_q    <= '0;
         buf_cnt_q <= '0;
         infl_q    <= 1'b0;
         buf0_q    <= '0;
         buf1_q    <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         rd_cnt_q  <= rd_cnt_d;
         beat_q    <= beat_d;
         buf_cnt_q <= buf_cnt_d;
         infl_q    <= infl_d;
         buf0_q    <= buf0_d;
         buf1_q    <= buf1_d;
      end
   end

   assign bus.o_busy    = (state_q == RUN);
   assign bus.o_done    = (state_q == DONE);
   assign bus.o_fifo_rd = rd;
   assign bus.o_vld     = (buf_cnt_q != 2'd0);
   assign bus.o_data    = buf0_q;
   assign bus.o_last    = last;

`ifdef CMIP_FIFO_BURST_RDR_STAT_EN
   logic [31:0] stat_q, stat_d;

   always_comb begin
      stat_d = stat_q;
      if (state_q == DONE) stat_d = stat_q + 32'd1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) stat_q <= '0;
      else       stat_q <= stat_d;
   end

   assign o_stat_bursts = stat_q;
`endif
endmodule

// File: tb/tb_cmip_fifo_burst_rdr.sv
// Directed bench for cmip_fifo_burst_rdr with a behavioural non-FWFT FIFO holding words 0x1000+i.
module tb_cmip_fifo_burst_rdr;
   localparam int DW = 32;
   localparam int LW = 16;

   logic i_clk = 1'b0;
   logic i_rst;
   always #5 i_clk = ~i_clk;

   cmip_fifo_burst_rdr_if #(.DATA_WDTH(DW), .LEN_WDTH(LW)) bus ();
`ifdef CMIP_FIFO_BURST_RDR_STAT_EN
   logic [31:0] stat;
`endif

   cmip_fifo_burst_rdr #(.DATA_WDTH(DW), .LEN_WDTH(LW)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
`ifdef CMIP_FIFO_BURST_RDR_STAT_EN
      .o_stat_bursts (stat),
`endif
      .bus           (bus.slave)
   );

   // FIFO model: registered dout, refilled from fill_tot requests.
   logic [DW-1:0] fq[$];
   int fill_tot = 0, filled = 0, rd_empty_err = 0;
   always @(posedge i_clk) begin
      if (bus.o_fifo_rd) begin
         if (fq.size() == 0) rd_empty_err <= rd_empty_err + 1;
         else bus.i_fifo_dout <= fq.pop_front();
      end
      for (int k = filled; k < fill_tot; k++) fq.push_back(DW'(32'h1000 + k));
      filled <= fill_tot;
      bus.i_fifo_empty <= (fq.size() == 0);
   end

   // Stream monitor sampled on the falling edge.
   int cyc = 0, stall_err = 0, occ = 0, occ_err = 0;
   int rd_cyc[$], beat_cyc[$], done_cyc[$];
   logic [DW-1:0] beat_dat[$];
   logic beat_lst[$];
   logic prev_stall = 1'b0, prev_l = 1'b0;
   logic [DW-1:0] prev_d = '0;
   always @(negedge i_clk) begin
      cyc <= cyc + 1;
      if (bus.o_fifo_rd) rd_cyc.push_back(cyc);
      if (bus.o_vld && bus.i_rdy) begin
         beat_dat.push_back(bus.o_data);
         beat_lst.push_back(bus.o_last);
         beat_cyc.push_back(cyc);
      end
      if (bus.o_done) done_cyc.push_back(cyc);
      if (prev_stall && !i_rst && (!bus.o_vld || bus.o_data != prev_d || bus.o_last != prev_l))
         stall_err <= stall_err + 1;
      prev_stall <= bus.o_vld && !bus.i_rdy;
      prev_d     <= bus.o_data;
      prev_l     <= bus.o_last;
      if (i_rst) occ <= 0;
      else begin
         if (occ > 2) occ_err <= occ_err + 1;
         occ <= occ + int'(bus.o_fifo_rd) - int'(bus.o_vld && bus.i_rdy);
      end
   end

   int n_chk = 0, n_pass = 0;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge i_clk); #1; end
   endtask

   task automatic fill(input int n);
      fill_tot += n;
      tick();
   endtask

   task automatic start(input int len);
      bus.i_start = 1'b1;
      bus.i_burst_len = LW'(len);
      tick();
      bus.i_start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 200 && !bus.o_done; k++) tick();
      chk(tag, bus.o_done, 1);
      tick();
   endtask

   task automatic check_beats(input string tag, input int b0, input int n, input int w0);
      chk({tag, "_nbeats"}, beat_dat.size() - b0, n);
      for (int k = 0; k < n && b0 + k < beat_dat.size(); k++) begin
         chk($sformatf("%s_data%0d", tag, k), beat_dat[b0+k], 32'h1000 + w0 + k);
         chk($sformatf("%s_last%0d", tag, k), beat_lst[b0+k], (k == n-1));
      end
   endtask

   int rb, bb, db, nxt;
   initial begin
      i_rst = 1'b1;
      bus.i_start = 1'b0;
      bus.i_burst_len = '0;
      bus.i_rdy = 1'b0;
      nxt = 0;
      tick(2);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_done", bus.o_done, 0);
      chk("rst_rd",   bus.o_fifo_rd, 0);
      chk("rst_vld",  bus.o_vld, 0);
      chk("rst_last", bus.o_last, 0);
      chk("rst_data", bus.o_data, 0);
      i_rst = 1'b0;
      tick();

      // len=4 from 8 preloaded words, always ready
      fill(8);
      tick();
      bus.i_rdy = 1'b1;
      rb = rd_cyc.size(); bb = beat_dat.size(); db = done_cyc.size();
      start(4);
      chk("t1_busy", bus.o_busy, 1);
      wait_done("t1_done");
      chk("t1_nrd", rd_cyc.size() - rb, 4);
      for (int k = 1; k < 4 && rb + k < rd_cyc.size(); k++)
         chk($sformatf("t1_rd_consec%0d", k), rd_cyc[rb+k] - rd_cyc[rb], k);
      check_beats("t1", bb, 4, nxt);
      if (beat_dat.size() - bb == 4 && rd_cyc.size() - rb == 4) begin
         chk("t1_latency", beat_cyc[bb] - rd_cyc[rb], 2);
         for (int k = 1; k < 4; k++)
            chk($sformatf("t1_beat_consec%0d", k), beat_cyc[bb+k] - beat_cyc[bb], k);
         chk("t1_done_after_last", done_cyc[db] - beat_cyc[bb+3], 1);
      end
      chk("t1_fifo_left", fq.size(), 4);
      nxt += 4;

      // len=8 with ready toggling every cycle
      fill(4);
      rb = rd_cyc.size(); bb = beat_dat.size();
      start(8);
      for (int k = 0; k < 100 && !bus.o_done; k++) begin
         bus.i_rdy = ~bus.i_rdy;
         tick();
      end
      chk("t2_done", bus.o_done, 1);
      bus.i_rdy = 1'b1;
      tick();
      chk("t2_nrd", rd_cyc.size() - rb, 8);
      check_beats("t2", bb, 8, nxt);
      chk("t2_stall_stable", stall_err, 0);
      chk("t2_occ", occ_err, 0);
      chk("t2_fifo_left", fq.size(), 0);
      nxt += 8;

      // len=3 against an empty FIFO that fills after 5 cycles
      rb = rd_cyc.size(); bb = beat_dat.size();
      start(3);
      tick(5);
      chk("t3_no_rd_empty", rd_cyc.size() - rb, 0);
      chk("t3_busy_wait", bus.o_busy, 1);
      fill(3);
      wait_done("t3_done");
      chk("t3_nrd", rd_cyc.size() - rb, 3);
      check_beats("t3", bb, 3, nxt);
      chk("t3_rd_empty", rd_empty_err, 0);
      nxt += 3;

      // zero-length burst
      rb = rd_cyc.size(); bb = beat_dat.size();
      start(0);
      chk("t4_done_next", bus.o_done, 1);
      chk("t4_rd", bus.o_fifo_rd, 0);
      chk("t4_vld", bus.o_vld, 0);
      tick();
      chk("t4_done_pulse", bus.o_done, 0);
      chk("t4_nrd", rd_cyc.size() - rb, 0);
      chk("t4_nbeat", beat_dat.size() - bb, 0);

      // start during RUN is ignored
      fill(2);
      rb = rd_cyc.size(); bb = beat_dat.size();
      start(2);
      bus.i_start = 1'b1;
      bus.i_burst_len = LW'(5);
      tick();
      bus.i_start = 1'b0;
      wait_done("t4b_done");
      chk("t4b_nrd", rd_cyc.size() - rb, 2);
      check_beats("t4b", bb, 2, nxt);
      chk("t4b_idle", bus.o_busy, 0);
      nxt += 2;

      // reset mid-burst with two beats parked
      fill(6);
      bus.i_rdy = 1'b0;
      start(4);
      tick(4);
      chk("t5_vld_pre", bus.o_vld, 1);
      chk("t5_data_pre", bus.o_data, 32'h1000 + nxt);
      chk("t5_rd_pre", bus.o_fifo_rd, 0);
      i_rst = 1'b1;
      #1;
      chk("t5_rst_busy", bus.o_busy, 0);
      chk("t5_rst_vld",  bus.o_vld, 0);
      chk("t5_rst_last", bus.o_last, 0);
      chk("t5_rst_data", bus.o_data, 0);
      chk("t5_rst_rd",   bus.o_fifo_rd, 0);
      chk("t5_rst_done", bus.o_done, 0);
      tick();
      i_rst = 1'b0;
      nxt += 2;
      bus.i_rdy = 1'b1;
      tick();
      bb = beat_dat.size();
      start(2);
      wait_done("t5_done");
      check_beats("t5", bb, 2, nxt);
      nxt += 2;
      chk("t5_fifo_left", fq.size(), 2);

`ifdef CMIP_FIFO_BURST_RDR_STAT_EN
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk("stat_rst", stat, 0);
      fill(4);
      start(1);
      wait_done("stat_b1");
      start(0);
      wait_done("stat_b2");
      start(5);
      wait_done("stat_b3");
      chk("stat_cnt", stat, 3);
`endif

      chk("end_rd_empty", rd_empty_err, 0);
      chk("end_occ", occ_err, 0);
      chk("end_stall", stall_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
